avalon_pipelined_io_slave: RTL and testbench

AVALON_PIPELINED_IO_SLAVE -- requirements
Module: avalon_pipelined_io_slave

---
 rtl/avalon_pipelined_io_slave_pkg.sv | 38 +++
 rtl/avalon_pipelined_io_slave_if.sv | 24 ++
 rtl/avalon_rsp_pipe.sv | 44 ++++
 rtl/avalon_pipelined_io_slave.sv | 141 ++++++++++++++
 tb/tb_avalon_pipelined_io_slave.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_pipelined_io_slave_pkg.sv
// Shared constants, request decode type and STATUS word packing for the
// pipelined I/O slave.
package avalon_pipelined_io_slave_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned NUM_REGS = 31;

  localparam logic [ADDR_W-1:0] STATUS_ADDR = 5'd31;

  localparam int unsigned ST_RD_LSB   = 0;
  localparam int unsigned ST_WR_LSB   = 8;
  localparam int unsigned ST_PEND_LSB = 16;
  localparam int unsigned ST_ERR_BIT  = 31;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_READ,
    OP_WRITE
  } op_e;

  function automatic logic [DATA_W-1:0] status_word(
    input logic [7:0] rd_count,
    input logic [7:0] wr_count,
    input logic [3:0] pending,
    input logic       err
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[ST_RD_LSB +: 8]   = rd_count;
    w[ST_WR_LSB +: 8]   = wr_count;
    w[ST_PEND_LSB +: 4] = pending;
    w[ST_ERR_BIT]       = err;
    return w;
  endfunction

endpackage

// File: rtl/avalon_pipelined_io_slave_if.sv
// Avalon-MM pipelined bus bundle between a master and the I/O slave.
interface avalon_pipelined_io_slave_if;
  import avalon_pipelined_io_slave_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              endofpacket;

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, endofpacket
  );

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, endofpacket
  );
endinterface

// File: rtl/avalon_rsp_pipe.sv
// Fixed-depth valid/data/eop shift register carrying read responses.
module avalon_rsp_pipe #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_eop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_eop
);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] eop;
  logic [WIDTH-1:0] dat [DEPTH];

  // Data and eop are zeroed on empty slots so the tail never shows stale values.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      eop <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      eop[0] <= in_valid & in_eop;
      dat[0] <= in_valid ? in_data : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        eop[i] <= eop[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_eop   = eop[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/avalon_pipelined_io_slave.sv
// Avalon-MM pipelined slave: 31 byte-writable registers plus a STATUS word,
// fixed read latency and a bounded number of outstanding reads.
module avalon_pipelined_io_slave
  import avalon_pipelined_io_slave_pkg::*;
#(
  parameter int unsigned       READ_LATENCY = 3,
  parameter int unsigned       MAX_PENDING  = 2,
  parameter logic [ADDR_W-1:0] EOP_ADDR     = 5'd30
) (
  input  logic                      clk,
  input  logic                      reset,
  avalon_pipelined_io_slave_if.slave bus,
  output logic [DATA_W-1:0]         ctrl_out
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [7:0]        rd_count;
  logic [7:0]        wr_count;
  logic [3:0]        pending;
  logic              err;
  logic              reset_hold;

  logic              waitrequest;
  op_e               op;
  logic              is_status;
  logic              conflict;
  logic              st_clear;
  logic [DATA_W-1:0] reg_rd;
  logic [DATA_W-1:0] rd_sample;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_eop;

  // Depends on registered state and the reset pin only, never on read/write.
  always_comb begin
    waitrequest = reset | reset_hold |
                  ((pending == 4'(MAX_PENDING)) & ~rsp_valid);
  end

  // A simultaneous read and write is handled purely as a write.
  always_comb begin
    op = OP_NONE;
    if (!waitrequest) begin
      if (bus.write) begin
        op = OP_WRITE;
      end else if (bus.read) begin
        op = OP_READ;
      end
    end
  end

  always_comb begin
    is_status = (bus.address == STATUS_ADDR);
    conflict  = (op == OP_WRITE) & bus.read;
    st_clear  = (op == OP_WRITE) & is_status & bus.byteenable[3] &
                bus.writedata[ST_ERR_BIT];
  end

  always_comb begin
    reg_rd = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.address == 5'(i)) begin
        reg_rd = regs[i];
      end
    end
  end

  // The STATUS read reports rd_count including the read being accepted.
  always_comb begin
    rd_sample = is_status ? status_word(rd_count + 8'd1, wr_count, pending, err)
                          : reg_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (op == OP_WRITE && !is_status) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (bus.address == 5'(i)) begin
          for (int unsigned b = 0; b < BE_W; b++) begin
            if (bus.byteenable[b]) begin
              regs[i][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count   <= '0;
      wr_count   <= '0;
      pending    <= '0;
      err        <= 1'b0;
      reset_hold <= 1'b1;
    end else begin
      reset_hold <= 1'b0;

      if (op == OP_READ && !rsp_valid) begin
        pending <= pending + 4'd1;
      end else if (op != OP_READ && rsp_valid) begin
        pending <= pending - 4'd1;
      end

      if (st_clear) begin
        rd_count <= '0;
        wr_count <= '0;
        err      <= 1'b0;
      end else begin
        if (op == OP_READ)  rd_count <= rd_count + 8'd1;
        if (op == OP_WRITE) wr_count <= wr_count + 8'd1;
        if (conflict)       err      <= 1'b1;
      end
    end
  end

  avalon_rsp_pipe #(
    .DEPTH (READ_LATENCY),
    .WIDTH (DATA_W)
  ) u_rsp_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (op == OP_READ),
    .in_data   (rd_sample),
    .in_eop    (bus.address == EOP_ADDR),
    .out_valid (rsp_valid),
    .out_data  (rsp_data),
    .out_eop   (rsp_eop)
  );

  assign bus.waitrequest   = waitrequest;
  assign bus.readdatavalid = rsp_valid;
  assign bus.readdata      = rsp_valid ? rsp_data : '0;
  assign bus.endofpacket   = rsp_valid & rsp_eop;
  assign ctrl_out          = regs[0];

endmodule

// File: tb/tb_avalon_pipelined_io_slave.sv
// Scoreboard bench for avalon_pipelined_io_slave: directed scenarios followed
// by randomized traffic against a transaction-level reference model.
module tb_avalon_pipelined_io_slave;
  import avalon_pipelined_io_slave_pkg::*;

  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXP = 2;
  localparam logic [4:0]  EOP  = 5'd30;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ctrl_out;

  always #5 clk = ~clk;

  avalon_pipelined_io_slave_if bus ();

  avalon_pipelined_io_slave #(
    .READ_LATENCY (LAT),
    .MAX_PENDING  (MAXP),
    .EOP_ADDR     (EOP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ctrl_out (ctrl_out)
  );

  typedef struct {
    logic [31:0] data;
    logic        eop;
    int unsigned due;
  } rsp_t;

  rsp_t        exp_q [$];
  int unsigned due_q [$];
  logic [31:0] m_regs [31];
  logic [7:0]  m_rd;
  logic [7:0]  m_wr;
  logic        m_err;

  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned errors = 0;
  bit          in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: each cycle, a response is due exactly when the oldest entry's due cycle arrives.
  initial begin
    bit   ev;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("readdatavalid", {31'b0, bus.readdatavalid}, {31'b0, ev});
        if (ev) begin
          r = exp_q.pop_front();
          check("readdata", bus.readdata, r.data);
          check("endofpacket", {31'b0, bus.endofpacket}, {31'b0, r.eop});
        end else begin
          check("readdata_idle", bus.readdata, 32'h0);
          check("eop_idle", {31'b0, bus.endofpacket}, 32'h0);
        end
        check("ctrl_out", ctrl_out, m_regs[0]);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 31; i++) m_regs[i] = '0;
    m_rd  = '0;
    m_wr  = '0;
    m_err = 1'b0;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic apply_model(input logic rd, input logic wr, input logic [4:0] a,
                             input logic [3:0] be, input logic [31:0] d,
                             input int unsigned pend);
    rsp_t r;
    if (wr) begin
      if (a != 5'd31) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) m_regs[int'(a)][8*b +: 8] = d[8*b +: 8];
        m_wr++;
        if (rd) m_err = 1'b1;
      end else if (be[3] && d[31]) begin
        m_rd  = '0;
        m_wr  = '0;
        m_err = 1'b0;
      end else begin
        m_wr++;
        if (rd) m_err = 1'b1;
      end
    end else begin
      m_rd++;
      if (a == 5'd31) r.data = {m_err, 11'b0, 4'(pend), m_wr, m_rd};
      else            r.data = m_regs[int'(a)];
      r.eop = (a == EOP);
      r.due = cyc + LAT;
      exp_q.push_back(r);
      due_q.push_back(cyc + LAT);
    end
  endtask

  // One bus cycle: predicts waitrequest from outstanding reads, drives inputs.
  task automatic step(input logic rd, input logic wr, input logic [4:0] a,
                      input logic [3:0] be, input logic [31:0] d, output bit acc);
    bit          ew;
    int unsigned pend;
    @(negedge clk);
    #1;
    while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
    pend = due_q.size();
    ew = (pend == MAXP) && !(pend > 0 && due_q[0] == cyc);
    check("waitrequest", {31'b0, bus.waitrequest}, {31'b0, ew});
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.byteenable = be;
    bus.writedata  = d;
    acc = (rd || wr) && !ew;
    if (acc) apply_model(rd, wr, a, be, d, pend);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [4:0] a,
                       input logic [3:0] be, input logic [31:0] d);
    bit acc;
    int n;
    n = 0;
    do begin
      step(rd, wr, a, be, d, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) check("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset     = 1'b1;
    in_reset  = 1'b1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    model_reset();
    #1 check("wait_in_reset", {31'b0, bus.waitrequest}, 32'h1);
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("wait_hold", {31'b0, bus.waitrequest}, 32'h1);
    check("rst_ctrl_out", ctrl_out, 32'h0);
    check("rst_rdv", {31'b0, bus.readdatavalid}, 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_eop", {31'b0, bus.endofpacket}, 32'h0);
    in_reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic [4:0] a;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.byteenable = '0;
    bus.writedata  = '0;
    model_reset();

    do_reset();
    issue(1'b0, 1'b1, 5'd3, 4'hF, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 5'd3, 4'h0, 32'h0);
    idle(5);
    issue(1'b0, 1'b1, 5'd3, 4'b0101, 32'h11223344);
    issue(1'b1, 1'b0, 5'd3, 4'h0, 32'h0);
    idle(5);
    check("merge_model", m_regs[3], 32'hDE22BE44);

    issue(1'b0, 1'b1, 5'd1, 4'hF, 32'hA1A1A1A1);
    issue(1'b0, 1'b1, 5'd2, 4'hF, 32'hB2B2B2B2);
    issue(1'b1, 1'b0, 5'd1, 4'h0, 32'h0);
    issue(1'b1, 1'b0, 5'd2, 4'h0, 32'h0);
    issue(1'b1, 1'b0, 5'd3, 4'h0, 32'h0);
    idle(6);

    issue(1'b0, 1'b1, 5'd30, 4'hF, 32'h30303030);
    issue(1'b1, 1'b0, 5'd30, 4'h0, 32'h0);
    idle(5);

    issue(1'b1, 1'b1, 5'd4, 4'hF, 32'hCAFEF00D);
    idle(2);
    issue(1'b1, 1'b0, 5'd4, 4'h0, 32'h0);
    issue(1'b1, 1'b0, 5'd31, 4'h0, 32'h0);
    idle(4);
    issue(1'b0, 1'b1, 5'd31, 4'h8, 32'h80000000);
    issue(1'b1, 1'b0, 5'd31, 4'h0, 32'h0);
    idle(5);

    issue(1'b0, 1'b1, 5'd0, 4'hF, 32'h12345678);
    issue(1'b1, 1'b0, 5'd5, 4'h0, 32'h0);
    do_reset();
    idle(6);

    repeat (400) begin
      kind = $urandom_range(0, 9);
      a    = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 0) ? 5'd30 : 5'd31;
      if ($urandom_range(0, 149) == 0) do_reset();
      else if (kind <= 3) issue(1'b1, 1'b0, a, 4'h0, 32'h0);
      else if (kind <= 6) issue(1'b0, 1'b1, a, 4'($urandom), $urandom);
      else if (kind == 7) issue(1'b1, 1'b1, a, 4'($urandom), $urandom);
      else idle(int'($urandom_range(1, 3)));
    end

    idle(12);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
